// File: rtl/dual_slope_pkg.sv
// rtl/dual_slope_pkg.sv - shared state encoding and default timing for the dual-slope controller
package dual_slope_pkg;

  localparam int DEF_AZ_CYCLES  = 256;
  localparam int DEF_INT_CYCLES = 2048;
  localparam int DEF_COUNT_W    = 12;

  // One-hot so the phase outputs come straight off state flops.
  typedef enum logic [3:0] {
    IDLE        = 4'b0001,
    AUTO_ZERO   = 4'b0010,
    INTEGRATE   = 4'b0100,
    DEINTEGRATE = 4'b1000
  } state_t;

  function automatic int timer_width(input int az_cycles, input int int_cycles);
    int longest;
    longest = (az_cycles > int_cycles) ? az_cycles : int_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/dual_slope_ctrl_if.sv
// rtl/dual_slope_ctrl_if.sv - request, comparator and result signals of the dual-slope controller
interface dual_slope_ctrl_if #(
  parameter int COUNT_W = dual_slope_pkg::DEF_COUNT_W
);

  logic               start_i;
  logic               cmp_i;
  logic               idle_o;
  logic               auto_zero_o;
  logic               integrate_o;
  logic               deintegrate_o;
  logic               ref_sign_o;
  logic               interrupt_o;
  logic [COUNT_W-1:0] measurement_count_o;
  logic               overflow_o;

  modport master (
    output start_i, cmp_i,
    input  idle_o, auto_zero_o, integrate_o, deintegrate_o,
    input  ref_sign_o, interrupt_o, measurement_count_o, overflow_o
  );

  modport slave (
    input  start_i, cmp_i,
    output idle_o, auto_zero_o, integrate_o, deintegrate_o,
    output ref_sign_o, interrupt_o, measurement_count_o, overflow_o
  );

endinterface

// File: rtl/dual_slope_phase_timer.sv
// rtl/dual_slope_phase_timer.sv - loadable down-counter with terminal-count flag for fixed-length phases
module dual_slope_phase_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Loading N-1 makes the phase last exactly N cycles including the tc cycle.
  assign tc = (count == '0);

endmodule

// File: rtl/dual_slope_ctrl.sv
// rtl/dual_slope_ctrl.sv - dual-slope ADC sequencer: auto-zero, fixed integrate, counted deintegrate
module dual_slope_ctrl
  import dual_slope_pkg::*;
#(
  parameter int AZ_CYCLES  = DEF_AZ_CYCLES,
  parameter int INT_CYCLES = DEF_INT_CYCLES,
  parameter int COUNT_W    = DEF_COUNT_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  dual_slope_ctrl_if.slave    bus
);

  localparam int TMR_W = timer_width(AZ_CYCLES, INT_CYCLES);
  localparam logic [TMR_W-1:0]   AZ_LOAD   = TMR_W'(AZ_CYCLES - 1);
  localparam logic [TMR_W-1:0]   INT_LOAD  = TMR_W'(INT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  state_t             state;
  logic               ref_sign_q;
  logic               irq_q;
  logic               ovf_q;
  logic [COUNT_W-1:0] meas_q;
  logic [COUNT_W-1:0] deint_cnt;

  logic               tmr_load;
  logic               tmr_dec;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_tc;

  always_comb begin
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_value = '0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          tmr_load  = 1'b1;
          tmr_value = AZ_LOAD;
        end
      end
      AUTO_ZERO: begin
        if (tmr_tc) begin
          tmr_load  = 1'b1;
          tmr_value = INT_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      INTEGRATE: tmr_dec = !tmr_tc;
      default: ;
    endcase
  end

  dual_slope_phase_timer #(.W(TMR_W)) u_phase_timer (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .tc         (tmr_tc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      ref_sign_q <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      meas_q     <= '0;
      deint_cnt  <= '0;
    end else begin
      irq_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) state <= AUTO_ZERO;
        end
        AUTO_ZERO: begin
          if (tmr_tc) state <= INTEGRATE;
        end
        INTEGRATE: begin
          if (tmr_tc) begin
            state      <= DEINTEGRATE;
            ref_sign_q <= bus.cmp_i;
            deint_cnt  <= '0;
          end
        end
        DEINTEGRATE: begin
          // A crossing takes precedence over saturation on the same cycle.
          if (bus.cmp_i != ref_sign_q) begin
            state  <= IDLE;
            meas_q <= deint_cnt;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b1;
          end else if (deint_cnt == COUNT_MAX) begin
            state  <= IDLE;
            meas_q <= COUNT_MAX;
            ovf_q  <= 1'b1;
            irq_q  <= 1'b1;
          end else begin
            deint_cnt <= deint_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.idle_o              = state[0];
  assign bus.auto_zero_o         = state[1];
  assign bus.integrate_o         = state[2];
  assign bus.deintegrate_o       = state[3];
  assign bus.ref_sign_o          = ref_sign_q;
  assign bus.interrupt_o         = irq_q;
  assign bus.measurement_count_o = meas_q;
  assign bus.overflow_o          = ovf_q;

endmodule

// File: doc/dual_slope_ctrl.md
DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
REQ-002   AZ_CYCLES, 256, auto-zero phase length in clocks (>=1).
REQ-003   INT_CYCLES, 2048, fixed integrate phase length in clocks (>=1).
REQ-004   COUNT_W, 12, measurement counter width.
REQ-005 Ports, one per line: name, direction, width, meaning.
REQ-006   clk_i, in, 1, sole clock; all state changes on the rising edge.
REQ-007   rst_n_i, in, 1, reset; synchronous, active-low.
REQ-008   start_i, in, 1, conversion request; sampled in IDLE only.
REQ-009   cmp_i, in, 1, integrator comparator (1 = integrator output positive).
REQ-010   idle_o, out, 1, high in IDLE.
REQ-011   auto_zero_o, out, 1, high in AUTO_ZERO.
REQ-012   integrate_o, out, 1, high in INTEGRATE.
REQ-013   deintegrate_o, out, 1, high in DEINTEGRATE.
REQ-014   ref_sign_o, out, 1, reference polarity for deintegrate (1 = negative reference).
REQ-015   interrupt_o, out, 1, one-cycle conversion-complete pulse.
REQ-016   measurement_count_o, out, COUNT_W, last conversion result.
REQ-017   overflow_o, out, 1, last result saturated.

Function
REQ-018 All outputs SHALL be registered; idle_o, auto_zero_o, integrate_o and deintegrate_o SHALL be one-hot at all times.
REQ-019 States SHALL be IDLE, AUTO_ZERO, INTEGRATE and DEINTEGRATE.
REQ-020 IDLE, start_i=1 at edge k: auto_zero_o SHALL be high from cycle k+1; start_i outside IDLE SHALL be ignored.
REQ-021 AUTO_ZERO SHALL last exactly AZ_CYCLES cycles, then INTEGRATE.
REQ-022 INTEGRATE SHALL last exactly INT_CYCLES cycles, then DEINTEGRATE.
REQ-023 On the last INTEGRATE cycle, ref_sign_o SHALL load cmp_i and hold until the next such load.
REQ-024 On entering DEINTEGRATE, the deintegrate counter SHALL clear to 0.
REQ-025 Each DEINTEGRATE cycle with cmp_i==ref_sign_o SHALL increment the counter by 1.
REQ-026 The first DEINTEGRATE cycle with cmp_i!=ref_sign_o SHALL end the phase (zero crossing); the result SHALL be the counter value, so a crossing on the first cycle gives 0.
REQ-027 If the counter reaches 2^COUNT_W-1 with no crossing, the phase SHALL end on the next cycle with result 2^COUNT_W-1 and overflow_o=1; otherwise overflow_o SHALL be 0 for that result.
REQ-028 On phase end, the next cycle SHALL be IDLE, and measurement_count_o, overflow_o and interrupt_o=1 SHALL all update in that same first IDLE cycle.
REQ-029 interrupt_o SHALL be high for exactly one cycle per conversion.
REQ-030 measurement_count_o and overflow_o SHALL hold their value until the next conversion completes.
REQ-031 start_i=1 in the interrupt cycle SHALL be accepted (back-to-back conversions).

Reset
REQ-032 rst_n_i=0 at any edge, including mid-conversion, SHALL force IDLE on the next cycle with idle_o=1, the other phase outputs 0, ref_sign_o=0, interrupt_o=0, measurement_count_o=0, overflow_o=0 and all counters 0.
REQ-033 start_i asserted while rst_n_i=0 SHALL have no effect.

Structure
REQ-034 Package dual_slope_pkg SHALL hold the state enum and the AZ_CYCLES, INT_CYCLES and COUNT_W defaults.
REQ-035 One sub-module, dual_slope_phase_timer (load/decrement with terminal-count flag), SHALL time AUTO_ZERO and INTEGRATE.
REQ-036 The deintegrate counter SHALL be in the top level.

Verification (AZ_CYCLES=4, INT_CYCLES=8, COUNT_W=12)
REQ-037 start_i pulse at cycle 0, cmp_i=1, cmp_i->0 after 100 DEINTEGRATE cycles -> auto_zero_o cycles 1-4, integrate_o 5-12, ref_sign_o=1, count=100, overflow_o=0, one interrupt_o pulse.
REQ-038 Same with cmp_i=0 at integrate end, cmp_i->1 on first DEINTEGRATE cycle -> ref_sign_o=0, count=0.
REQ-039 cmp_i held equal to ref_sign_o -> count=4095, overflow_o=1, DEINTEGRATE lasts 4096 cycles.
REQ-040 rst_n_i=0 for one cycle during INTEGRATE -> IDLE next cycle, all outputs at reset values, no interrupt_o.
REQ-041 start_i held high continuously -> back-to-back conversions, new AUTO_ZERO starts the cycle after the interrupt cycle, start ignored mid-conversion.
REQ-042 Every cycle: phase outputs one-hot; interrupt_o never high two consecutive cycles.
